// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan controller: segment table,
// scan phase encoding and a width helper.
package sseg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } phase_e;

    // Active-high segment patterns, bit order gfedcba, indexed by hex value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int width_for(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Load port of the scan controller: a valid/ready write of digit data.
interface sseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 2
);
    logic [4*NUM_DIGITS-1:0] in_data;
    logic [NUM_DIGITS-1:0]   in_dp;
    logic                    in_lz_en;
    logic                    in_valid;
    logic                    in_ready;

    modport master (
        output in_data, in_dp, in_lz_en, in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data, in_dp, in_lz_en, in_valid,
        output in_ready
    );
endinterface

// File: rtl/sseg_hex_decode.sv
// Combinational nibble to active-high seven-segment decoder.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);
    assign segs = HEX_SEG[nibble];
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multi-digit seven-segment scanner with blanking, leading-zero suppression
// and a double-buffered load port that only swaps at frame boundaries.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int DWELL_CYCLES   = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                  CLK,
    input  logic                  reset,
    sseg_scan_ctrl_if.slave       load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_tick
);
    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = width_for(MAX_CNT + 1);
    localparam int DW      = width_for(NUM_DIGITS);
    localparam int NB      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0]         DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [DW-1:0]         DIGIT_LAST = DW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = SEL_ACTIVE_LOW ? '1 : '0;

    phase_e          phase, phase_next;
    logic [DW-1:0]   digit, digit_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            frame_end;

    logic [NB-1:0]         act_data, pend_data;
    logic [NUM_DIGITS-1:0] act_dp, pend_dp;
    logic                  act_lz, pend_lz, pend_valid;
    logic                  accept;

    logic [NB-1:0]         data_shift;
    logic [NUM_DIGITS-1:0] dp_shift;
    logic [NUM_DIGITS-1:0] sel_on;
    logic [6:0]            seg_raw;
    logic                  lz_blank;

    always_ff @(posedge CLK) begin
        if (reset) begin
            phase <= BLANK;
            digit <= '0;
            cnt   <= '0;
        end else begin
            phase <= phase_next;
            digit <= digit_next;
            cnt   <= cnt_next;
        end
    end

    // With BLANK_CYCLES=0 the blank phase only occurs once, straight after reset
    always_comb begin
        phase_next = phase;
        digit_next = digit;
        cnt_next   = cnt + CW'(1);
        frame_end  = 1'b0;
        case (phase)
            BLANK: begin
                if (BLANK_CYCLES == 0 || cnt == BLANK_LAST) begin
                    phase_next = ON;
                    cnt_next   = '0;
                end
            end
            ON: begin
                if (cnt == DWELL_LAST) begin
                    cnt_next   = '0;
                    frame_end  = (digit == DIGIT_LAST);
                    digit_next = (digit == DIGIT_LAST) ? '0 : digit + DW'(1);
                    phase_next = (BLANK_CYCLES == 0) ? ON : BLANK;
                end
            end
            default: phase_next = BLANK;
        endcase
    end

    assign load.in_ready = ~pend_valid | frame_end;
    assign accept        = load.in_valid & load.in_ready;

    // Active is promoted before the pending slot is refilled in the same cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            act_data   <= '0;
            act_dp     <= '0;
            act_lz     <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            if (frame_end && pend_valid) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
                act_lz   <= pend_lz;
            end
            if (accept) begin
                pend_data  <= load.in_data;
                pend_dp    <= load.in_dp;
                pend_lz    <= load.in_lz_en;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        data_shift = act_data >> {digit, 2'b00};
        dp_shift   = act_dp >> digit;
        sel_on     = NUM_DIGITS'(1) << digit;
        lz_blank   = act_lz && (digit != '0) && (data_shift == '0);
    end

    sseg_hex_decode u_decode (
        .nibble (data_shift[3:0]),
        .segs   (seg_raw)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            dig_sel    <= SEL_OFF;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            if (phase == ON) begin
                dig_sel <= SEL_ACTIVE_LOW ? ~sel_on : sel_on;
                if (lz_blank) begin
                    seg <= SEG_OFF;
                    dp  <= DP_OFF;
                end else begin
                    seg <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
                    dp  <= dp_shift[0] ^ DP_OFF;
                end
            end else begin
                seg     <= SEG_OFF;
                dp      <= DP_OFF;
                dig_sel <= SEL_OFF;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench: frame-position model of the scanner plus directed
// literal checks, random loads, a mid-frame reset and a no-blank instance.
module tb_sseg_scan_ctrl;
    localparam int N     = 4;
    localparam int D     = 8;
    localparam int B     = 2;
    localparam int SLOT  = B + D;
    localparam int FRAME = N * SLOT;

    logic CLK = 1'b0;
    logic reset;
    logic reset2;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    sseg_scan_ctrl_if #(.NUM_DIGITS(N)) ld ();
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] dig_sel;
    logic         frame_tick;

    sseg_scan_ctrl #(
        .NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
    ) dut (
        .CLK(CLK), .reset(reset), .load(ld),
        .seg(seg), .dp(dp), .dig_sel(dig_sel), .frame_tick(frame_tick)
    );

    sseg_scan_ctrl_if #(.NUM_DIGITS(1)) ld2 ();
    logic [6:0] seg2;
    logic       dp2;
    logic [0:0] sel2;
    logic       tick2;

    sseg_scan_ctrl #(
        .NUM_DIGITS(1), .DWELL_CYCLES(8), .BLANK_CYCLES(0),
        .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
    ) dut2 (
        .CLK(CLK), .reset(reset2), .load(ld2),
        .seg(seg2), .dp(dp2), .dig_sel(sel2), .frame_tick(tick2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [6:0] seg_pattern(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            default: return 7'b1110001;
        endcase
    endfunction

    // Reference model: display state derived from position within the frame
    int          m_pos;
    bit          m_seen = 1'b0;
    logic [15:0] m_act, m_pend, m_sh;
    logic [3:0]  m_act_dp, m_pend_dp;
    logic        m_act_lz, m_pend_lz, m_pend_v;
    int          m_dg, m_within;
    logic        m_fe, m_acc;
    logic [6:0]  e_seg;
    logic        e_dp, e_tick;
    logic [3:0]  e_sel;

    always @(posedge CLK) begin
        if (reset) begin
            m_seen = 1'b1;
            m_pos = 0;
            m_act = '0; m_act_dp = '0; m_act_lz = 1'b0;
            m_pend = '0; m_pend_dp = '0; m_pend_lz = 1'b0; m_pend_v = 1'b0;
            e_seg = 7'h7F; e_dp = 1'b1; e_sel = '0; e_tick = 1'b0;
        end else if (m_seen) begin
            m_dg     = m_pos / SLOT;
            m_within = m_pos % SLOT;
            m_fe     = (m_pos == FRAME - 1);
            e_tick   = m_fe;
            if (m_within < B) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_sel = '0;
            end else begin
                e_sel = 4'(1 << m_dg);
                m_sh  = m_act >> (4 * m_dg);
                if (m_act_lz && m_dg > 0 && m_sh == 16'h0) begin
                    e_seg = 7'h7F; e_dp = 1'b1;
                end else begin
                    e_seg = ~seg_pattern(m_sh[3:0]);
                    e_dp  = ~m_act_dp[m_dg];
                end
            end
            m_acc = ld.in_valid && (!m_pend_v || m_fe);
            if (m_fe && m_pend_v) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_act_lz = m_pend_lz;
            end
            if (m_acc) begin
                m_pend = ld.in_data; m_pend_dp = ld.in_dp; m_pend_lz = ld.in_lz_en; m_pend_v = 1'b1;
            end else if (m_fe) begin
                m_pend_v = 1'b0;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        #1;
        if (m_seen) begin
            checkOutput("seg", 32'(seg), 32'(e_seg));
            checkOutput("dp", 32'(dp), 32'(e_dp));
            checkOutput("dig_sel", 32'(dig_sel), 32'(e_sel));
            checkOutput("frame_tick", 32'(frame_tick), 32'(e_tick));
            checkOutput("in_ready", 32'(ld.in_ready), 32'(!m_pend_v || m_pos == FRAME - 1));
        end
    end

    // Single-digit, no-blank instance: constant select, tick every 8 clocks
    int gap2 = 0;
    int ticks2 = 0;
    always @(negedge CLK) begin
        if (reset2) begin
            gap2 = 0; ticks2 = 0;
        end else begin
            gap2++;
            if (tick2) begin
                if (ticks2 > 0) checkOutput("dut2_tick_gap", 32'(gap2), 32'd8);
                ticks2++;
                gap2 = 0;
            end
            if (ticks2 > 0) begin
                checkOutput("dut2_sel", 32'(sel2), 32'd1);
                checkOutput("dut2_seg", 32'(seg2), 32'h40);
            end
        end
    end

    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge CLK);
        while (!frame_tick && n < 4 * FRAME) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!frame_tick) begin
            failures++;
            $display("[TB] FAIL tick_timeout frame_tick=%0b required=1", frame_tick);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dpv, input logic lz);
        ld.in_data  = data;
        ld.in_dp    = dpv;
        ld.in_lz_en = lz;
        ld.in_valid = 1'b1;
        @(negedge CLK);
        ld.in_valid = 1'b0;
    endtask

    initial begin
        ld.in_valid = 1'b0; ld.in_data = '0; ld.in_dp = '0; ld.in_lz_en = 1'b0;
        ld2.in_valid = 1'b0; ld2.in_data = '0; ld2.in_dp = '0; ld2.in_lz_en = 1'b0;
        reset = 1'b1; reset2 = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("reset_seg", 32'(seg), 32'h7F);
        checkOutput("reset_sel", 32'(dig_sel), 32'h0);
        checkOutput("reset_ready", 32'(ld.in_ready), 32'h1);
        reset = 1'b0; reset2 = 1'b0;

        $display("[TB] idle scan");
        wait_tick();
        repeat (3) @(negedge CLK);
        checkOutput("idle_d0_seg", 32'(seg), 32'h40);
        checkOutput("idle_d0_sel", 32'(dig_sel), 32'h1);

        $display("[TB] mid-frame load");
        repeat (12) @(negedge CLK);
        applyStimulus(16'h12AF, 4'b0100, 1'b0);
        checkOutput("load_ready_low", 32'(ld.in_ready), 32'h0);
        wait_tick();
        repeat (3) @(negedge CLK);
        checkOutput("load_d0_seg", 32'(seg), 32'h0E);
        checkOutput("load_d0_sel", 32'(dig_sel), 32'h1);
        repeat (20) @(negedge CLK);
        checkOutput("load_d2_seg", 32'(seg), 32'h24);
        checkOutput("load_d2_dp", 32'(dp), 32'h0);
        repeat (10) @(negedge CLK);
        checkOutput("load_d3_seg", 32'(seg), 32'h79);
        checkOutput("load_d3_sel", 32'(dig_sel), 32'h8);

        $display("[TB] leading-zero suppression");
        applyStimulus(16'h0005, 4'b0000, 1'b1);
        wait_tick();
        repeat (3) @(negedge CLK);
        checkOutput("lz_d0_seg", 32'(seg), 32'h12);
        repeat (10) @(negedge CLK);
        checkOutput("lz_d1_seg", 32'(seg), 32'h7F);
        checkOutput("lz_d1_sel", 32'(dig_sel), 32'h2);
        applyStimulus(16'h0005, 4'b0000, 1'b0);
        wait_tick();
        repeat (13) @(negedge CLK);
        checkOutput("nolz_d1_seg", 32'(seg), 32'h40);

        $display("[TB] held valid");
        ld.in_valid = 1'b1;
        repeat (3 * FRAME) begin
            ld.in_data  = 16'($urandom);
            ld.in_dp    = 4'($urandom);
            ld.in_lz_en = 1'($urandom);
            @(negedge CLK);
        end
        ld.in_valid = 1'b0;

        $display("[TB] random loads");
        repeat (800) begin
            ld.in_valid = ($urandom_range(0, 7) == 0);
            ld.in_data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            ld.in_dp    = 4'($urandom);
            ld.in_lz_en = 1'($urandom);
            @(negedge CLK);
        end
        ld.in_valid = 1'b0;

        $display("[TB] reset with pending data");
        wait_tick();
        repeat (13) @(negedge CLK);
        applyStimulus(16'hBEEF, 4'hF, 1'b0);
        repeat (9) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_sel", 32'(dig_sel), 32'h0);
        checkOutput("rst_dp", 32'(dp), 32'h1);
        checkOutput("rst_ready", 32'(ld.in_ready), 32'h1);
        reset = 1'b0;
        wait_tick();
        repeat (3) @(negedge CLK);
        checkOutput("rst_d0_seg", 32'(seg), 32'h40);
        repeat (2 * FRAME) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
